player1_ctrl: RTL and testbench

Position and animation controller for player 1. Once per video frame it samples the direction buttons, proposes a candidate position to the map collision checker over a valid/ack handshake, and commits the move if it is not blocked. It drives `centerX1`, `centerY1` and `sprite_num`, the inputs of the player 1 sprite renderer, so it is the producing end of that interface.

---
 rtl/bomberman_pkg.sv | 79 +++++++
 rtl/player_anim.sv | 63 ++++++
 rtl/player1_ctrl.sv | 125 ++++++++++++
 tb/tb_player1_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// Shared types and constants for the bomberman video game.
// Screen geometry, directions and sprite frame indices.
package bomberman_pkg;

  typedef enum logic [2:0] {
    NONE,
    UP,
    DOWN,
    LEFT,
    RIGHT
  } dir_t;

  localparam int HACTIVE     = 800;
  localparam int VACTIVE     = 600;
  localparam int SPRITE_SIZE = 32;

  localparam int X_MAX = HACTIVE - SPRITE_SIZE;
  localparam int Y_MAX = VACTIVE - SPRITE_SIZE;

  localparam logic [2:0] SPR_IDLE  = 3'd0;
  localparam logic [2:0] SPR_DOWN0 = 3'd1;
  localparam logic [2:0] SPR_DOWN1 = 3'd2;
  localparam logic [2:0] SPR_UP0   = 3'd3;
  localparam logic [2:0] SPR_UP1   = 3'd4;
  localparam logic [2:0] SPR_LEFT  = 3'd5;
  localparam logic [2:0] SPR_RIGHT = 3'd6;

  // Opposite presses resolve by priority up > down > left > right.
  function automatic dir_t decode_dir(
    input logic up,
    input logic down,
    input logic left,
    input logic right
  );
    dir_t d;
    d = NONE;
    priority case (1'b1)
      up:      d = UP;
      down:    d = DOWN;
      left:    d = LEFT;
      right:   d = RIGHT;
      default: d = NONE;
    endcase
    return d;
  endfunction

  // Saturate a 12-bit signed coordinate into [0, hi].
  function automatic logic signed [10:0] clamp_axis(
    input logic signed [11:0] v,
    input int                 hi
  );
    logic signed [10:0] r;
    if (v[11]) begin
      r = '0;
    end else if (v > 12'(hi)) begin
      r = 11'(hi);
    end else begin
      r = v[10:0];
    end
    return r;
  endfunction

  function automatic logic [2:0] sprite_of(
    input dir_t d,
    input logic ph
  );
    logic [2:0] s;
    s = SPR_IDLE;
    unique case (d)
      UP:      s = ph ? SPR_UP1 : SPR_UP0;
      DOWN:    s = ph ? SPR_DOWN1 : SPR_DOWN0;
      LEFT:    s = SPR_LEFT;
      RIGHT:   s = SPR_RIGHT;
      default: s = SPR_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/player_anim.sv
// Walk animation state for one player.
// Counter, phase and facing, updated on commit or idle clear.
module player_anim
  import bomberman_pkg::*;
#(
  parameter int ANIM_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       commit,
  input  logic       clear,
  input  dir_t       dir,
  input  logic       blocked,
  output logic [2:0] sprite_num
);

  localparam int CW =
    (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(ANIM_DIV - 1);

  logic [CW-1:0] cnt, cnt_n;
  logic          phase, phase_n;
  dir_t          last_dir;
  logic          same;

  // Next counter/phase for a commit: advance on a continued walk.
  always_comb begin
    cnt_n   = '0;
    phase_n = 1'b0;
    same    = (dir == last_dir) && !blocked;
    if (same) begin
      if (cnt == CNT_MAX) begin
        cnt_n   = '0;
        phase_n = ~phase;
      end else begin
        cnt_n   = cnt + 1'b1;
        phase_n = phase;
      end
    end
  end

  // Animation registers; facing follows dir even when blocked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      phase      <= 1'b0;
      last_dir   <= NONE;
      sprite_num <= SPR_IDLE;
    end else if (clear) begin
      cnt        <= '0;
      phase      <= 1'b0;
      last_dir   <= NONE;
      sprite_num <= SPR_IDLE;
    end else if (commit) begin
      cnt        <= cnt_n;
      phase      <= phase_n;
      last_dir   <= dir;
      sprite_num <= sprite_of(dir, phase_n);
    end
  end

endmodule

// File: rtl/player1_ctrl.sv
// Player 1 position controller.
// Per-frame move request to the collision checker, commit on ack.
module player1_ctrl
  import bomberman_pkg::*;
#(
  parameter int START_X  = 32,
  parameter int START_Y  = 32,
  parameter int STEP     = 2,
  parameter int ANIM_DIV = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  output logic               cand_valid,
  output logic signed [10:0] cand_x,
  output logic signed [10:0] cand_y,
  input  logic               cand_ack,
  input  logic               cand_blocked,
  output logic signed [10:0] centerX1,
  output logic signed [10:0] centerY1,
  output logic [2:0]         sprite_num
);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  localparam logic signed [11:0] STEP12 =
    12'(STEP);

  state_t             state, state_n;
  dir_t               dir_in, dir_q;
  logic signed [11:0] x_w, y_w;
  logic signed [10:0] nxt_x, nxt_y;
  logic               tick_go, tick_none;
  logic               accept;

  assign dir_in = decode_dir(
    btn_up, btn_down, btn_left, btn_right);

  assign tick_go   = (state == IDLE) && frame_tick
                  && (dir_in != NONE);
  assign tick_none = (state == IDLE) && frame_tick
                  && (dir_in == NONE);
  assign accept    = (state == REQ) && cand_valid
                  && cand_ack;

  // Candidate one step away, widened so edges never wrap.
  always_comb begin
    x_w = {centerX1[10], centerX1};
    y_w = {centerY1[10], centerY1};
    unique case (dir_in)
      UP:      y_w = y_w - STEP12;
      DOWN:    y_w = y_w + STEP12;
      LEFT:    x_w = x_w - STEP12;
      RIGHT:   x_w = x_w + STEP12;
      default: ;
    endcase
    nxt_x = clamp_axis(x_w, X_MAX);
    nxt_y = clamp_axis(y_w, Y_MAX);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state: request on a directed tick, return on ack.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (tick_go) state_n = REQ;
      REQ:  if (accept)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake and position registers; all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_valid <= 1'b0;
      cand_x     <= 11'(START_X);
      cand_y     <= 11'(START_Y);
      centerX1   <= 11'(START_X);
      centerY1   <= 11'(START_Y);
      dir_q      <= NONE;
    end else begin
      if (tick_go) begin
        cand_valid <= 1'b1;
        cand_x     <= nxt_x;
        cand_y     <= nxt_y;
        dir_q      <= dir_in;
      end
      if (accept) begin
        cand_valid <= 1'b0;
        if (!cand_blocked) begin
          centerX1 <= cand_x;
          centerY1 <= cand_y;
        end
      end
    end
  end

  player_anim #(
    .ANIM_DIV (ANIM_DIV)
  ) u_anim (
    .clk        (clk),
    .reset      (reset),
    .commit     (accept),
    .clear      (tick_none),
    .dir        (dir_q),
    .blocked    (cand_blocked),
    .sprite_num (sprite_num)
  );

endmodule

// File: tb/tb_player1_ctrl.sv
// Bench for player1_ctrl.
// Frame-level model plus directed literal checks.
module tb_player1_ctrl;

  logic               clk = 1'b0;
  logic               reset;
  logic               frame_tick;
  logic               btn_up, btn_down;
  logic               btn_left, btn_right;
  logic               cand_valid;
  logic signed [10:0] cand_x, cand_y;
  logic               cand_ack, cand_blocked;
  logic signed [10:0] centerX1, centerY1;
  logic [2:0]         sprite_num;

  int tests  = 0;
  int failed = 0;

  // model state; dirs: 0 none 1 up 2 down 3 left 4 right
  int mx, my, mcx, mcy;
  int mrun, mlast, mdir, mspr;
  bit mvalid;

  always #5 clk = ~clk;

  player1_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .cand_valid   (cand_valid),
    .cand_x       (cand_x),
    .cand_y       (cand_y),
    .cand_ack     (cand_ack),
    .cand_blocked (cand_blocked),
    .centerX1     (centerX1),
    .centerY1     (centerY1),
    .sprite_num   (sprite_num)
  );

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int pick(bit u, bit d,
                              bit l, bit r);
    if (u) return 1;
    if (d) return 2;
    if (l) return 3;
    if (r) return 4;
    return 0;
  endfunction

  function automatic int dxof(int d);
    return d == 4 ? 1 : (d == 3 ? -1 : 0);
  endfunction

  function automatic int dyof(int d);
    return d == 2 ? 1 : (d == 1 ? -1 : 0);
  endfunction

  // run = same-dir unblocked commits since direction began
  function automatic int nrun(bit b, int d,
                              int l, int r);
    return (!b && d == l) ? r + 1 : 0;
  endfunction

  function automatic int spr(int d, int run);
    int ph;
    ph = (run / 8) % 2;
    case (d)
      1: return 3 + ph;
      2: return 1 + ph;
      3: return 5;
      4: return 6;
      default: return 0;
    endcase
  endfunction

  // frame-level behavioural model
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mx <= 32; my <= 32;
      mcx <= 32; mcy <= 32;
      mrun <= 0; mlast <= 0;
      mdir <= 0; mspr <= 0;
      mvalid <= 1'b0;
    end else if (!mvalid) begin
      if (frame_tick) begin
        if (pick(btn_up, btn_down,
                 btn_left, btn_right) == 0) begin
          mspr  <= 0;
          mrun  <= 0;
          mlast <= 0;
        end else begin
          mvalid <= 1'b1;
          mdir <= pick(btn_up, btn_down,
                       btn_left, btn_right);
          mcx <= clampi(mx + 2 * dxof(pick(btn_up,
                   btn_down, btn_left, btn_right)),
                   768);
          mcy <= clampi(my + 2 * dyof(pick(btn_up,
                   btn_down, btn_left, btn_right)),
                   568);
        end
      end
    end else if (cand_ack) begin
      mvalid <= 1'b0;
      if (!cand_blocked) begin
        mx <= mcx;
        my <= mcy;
      end
      mrun  <= nrun(cand_blocked, mdir, mlast, mrun);
      mlast <= mdir;
      mspr  <= spr(mdir,
                   nrun(cand_blocked, mdir, mlast, mrun));
    end
  end

  // compare DUT to model every cycle
  always @(negedge clk) begin
    chk("cand_valid", int'(cand_valid), int'(mvalid));
    if (mvalid) begin
      chk("cand_x", int'(cand_x), mcx);
      chk("cand_y", int'(cand_y), mcy);
    end
    chk("centerX1", int'(centerX1), mx);
    chk("centerY1", int'(centerY1), my);
    chk("sprite_num", int'(sprite_num), mspr);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic ackp(input bit b);
    cand_ack     = 1'b1;
    cand_blocked = b;
    cyc(1);
    cand_ack     = 1'b0;
    cand_blocked = 1'b0;
  endtask

  task automatic frame(input bit b);
    tick();
    ackp(b);
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 0; cand_ack = 0; cand_blocked = 0;
    btn_up = 0; btn_down = 0;
    btn_left = 0; btn_right = 0;
    cyc(3);
    reset = 1'b0;
    cyc(6);
    chk("rst_x", int'(centerX1), 32);
    chk("rst_y", int'(centerY1), 32);
    chk("rst_spr", int'(sprite_num), 0);
    chk("rst_valid", int'(cand_valid), 0);

    btn_right = 1;
    for (int i = 0; i < 10; i++) begin
      frame(0);
      if (i == 0) chk("right_spr", int'(sprite_num), 6);
    end
    chk("right_x", int'(centerX1), 52);
    btn_right = 0;
    tick();
    chk("none_spr", int'(sprite_num), 0);
    chk("none_valid", int'(cand_valid), 0);

    btn_down = 1;
    for (int i = 0; i < 16; i++) begin
      frame(0);
      chk("down_spr", int'(sprite_num), i < 8 ? 1 : 2);
    end
    chk("down_y", int'(centerY1), 64);
    btn_down = 0;

    btn_up = 1;
    tick();
    chk("up_cand_y", int'(cand_y), 62);
    ackp(1);
    chk("blk_y", int'(centerY1), 64);
    chk("blk_spr", int'(sprite_num), 3);
    btn_left = 1;
    tick();
    chk("pri_cand_x", int'(cand_x), 52);
    chk("pri_cand_y", int'(cand_y), 62);
    ackp(0);
    chk("pri_y", int'(centerY1), 62);
    chk("pri_spr", int'(sprite_num), 3);
    btn_left = 0; btn_up = 0;

    ackp(0);
    chk("idle_ack_y", int'(centerY1), 62);
    chk("idle_ack_v", int'(cand_valid), 0);

    btn_right = 1;
    tick();
    cyc(2);
    tick();
    cyc(2);
    chk("hold_valid", int'(cand_valid), 1);
    chk("hold_cx", int'(cand_x), 54);
    ackp(0);
    chk("hold_x", int'(centerX1), 54);
    cyc(4);
    chk("drop_valid", int'(cand_valid), 0);
    chk("drop_x", int'(centerX1), 54);

    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_v", int'(cand_valid), 0);
    chk("mid_rst_x", int'(centerX1), 32);
    chk("mid_rst_y", int'(centerY1), 32);
    chk("mid_rst_s", int'(sprite_num), 0);
    cyc(1);
    reset = 1'b0;
    btn_right = 0;
    cyc(2);

    btn_up = 1;
    for (int i = 0; i < 16; i++) frame(0);
    chk("top_y", int'(centerY1), 0);
    tick();
    chk("top_cand_y", int'(cand_y), 0);
    ackp(0);
    btn_up = 0;

    btn_right = 1;
    for (int i = 0; i < 367; i++) frame(0);
    chk("edge_x", int'(centerX1), 766);
    tick();
    chk("edge_cx1", int'(cand_x), 768);
    ackp(0);
    tick();
    chk("edge_cx2", int'(cand_x), 768);
    ackp(0);
    chk("edge_x2", int'(centerX1), 768);
    chk("edge_spr", int'(sprite_num), 6);
    btn_right = 0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end

endmodule
